muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide sequencer for the integer core. It executes the `mult`, `multu`, `div` and `divu` functions, which the single-cycle ALU does not complete. It owns the architectural HI/LO registers and sits beside the ALU in the execute stage. Decode raises `start`, holds the pipeline while `busy` is high, and reads HI/LO for `mfhi`/`mflo`.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request an operation; sampled only in IDLE
- func  in  6  function code, same encoding as the ALU `func`: mult 011000, multu 011001, div 011010, divu 011011
- operand_a  in  WIDTH  multiplicand or dividend; also the data for hi_we/lo_we
- operand_b  in  WIDTH  multiplier or divisor
- hi_we  in  1  `mthi`: write operand_a to HI
- lo_we  in  1  `mtlo`: write operand_a to LO
- cancel  in  1  abort the operation in flight (pipeline flush)
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when HI/LO hold a new result
- div_by_zero  out  1  valid with done; high for div/divu with operand_b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, PREP, RUN, FIX.
- IDLE to PREP: start=1 with a valid func. Operands and func are latched on that edge. Any other func leaves the block in IDLE and has no effect.
- PREP (1 cycle):
  - Signed ops take absolute values of both operands and record the result sign and remainder sign.
  - Unsigned ops pass the operands through unchanged.
  - The iteration counter is cleared.
- RUN (WIDTH cycles): one step per cycle.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
- FIX (1 cycle):
  - Conditional two's-complement negation of the results.
  - HI/LO are loaded on the exit edge; the state returns to IDLE.
- Multiply results: {hi, lo} = full 2·WIDTH product. Signed and unsigned products are both exact.
- Divide results: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Signed overflow 0x80000000 / −1: lo = 0x80000000, hi = 0. No flag is raised.
- Divide by zero:
  - The operation runs with normal latency.
  - Result: lo = all-ones, hi = dividend (raw operand_a), div_by_zero = 1.
- hi_we / lo_we:
  - Honoured only in IDLE and ignored while busy.
  - If either coincides with an accepted start, the write takes effect and is overwritten at completion.
- cancel:
  - In PREP, RUN or FIX: state goes to IDLE on the next edge. HI/LO are unchanged and there is no done pulse.
  - In IDLE, cancel is ignored.
  - If cancel and start occur in the same IDLE cycle, start wins.
- start while busy: ignored. The operation in flight is unaffected.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi 0, lo 0. The internal accumulator and counter are cleared.
- rst_n asserted mid-operation: everything returns to reset values immediately, asynchronously.
- Latency, with start accepted at edge N:
  - busy = 1 from edge N through edge N+WIDTH+2.
  - At edge N+WIDTH+2: HI/LO are updated, done = 1 and busy = 0 together.
  - For WIDTH = 32 the latency is 34 cycles.
- done and div_by_zero:
  - Both are registered and high for exactly one cycle.
  - div_by_zero is 0 for mult/multu.
- Back-to-back issue: a new start is accepted in the same cycle done is high. The next result arrives 34 cycles later, so the issue rate is one operation per WIDTH+2 cycles.
- hi and lo are registered outputs with no combinational path from any input.

## Structure
- Shared core package holds:
  - the 6-bit func code constants, used by the ALU and this block
  - the state encoding (IDLE, PREP, RUN, FIX)
- One sub-module, `muldiv_step`: combinational single-iteration datapath (shift-add or shift-subtract, selected by a mul/div flag).
- The top level keeps the FSM, counter, sign bookkeeping and HI/LO.

## Test plan
- multu 100 × 75 → hi = 0, lo = 7500; done exactly 34 cycles after start; busy high for the interval in between.
- mult 99999 × −999 → hi = 0xFFFFFFFF, lo = 0xFA0BA987. multu 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- div −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. div 0x80000000 / −1 → lo = 0x80000000, hi = 0, div_by_zero = 0.
- divu 999 / 0 → lo = 0xFFFFFFFF, hi = 999, div_by_zero = 1 for one cycle with done.
- During a divu 9999/9999, pulse start (mult 7×7), then hi_we:
  - Both are ignored; result lo = 1, hi = 0.
  - Next start accepted in the done cycle: mult 7×7 completes with lo = 49.
- Cancel at cycle 10 of an op → busy drops next edge, no done, HI/LO retain prior values. Separately, drop rst_n mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared core definitions: ALU/muldiv function codes and the muldiv FSM encoding.
package muldiv_ctrl_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  function automatic logic is_muldiv_func(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_next.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifting left.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, operand};
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer that owns the architectural HI/LO registers.
// Latency: WIDTH+2 cycles from accepted start to done (PREP, WIDTH x RUN, FIX).
// Backpressure: busy holds decode; start is ignored while busy, cancel aborts in flight.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   b_r;
  logic               is_div;
  logic               is_signed;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != ST_IDLE);

  assign a_abs = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
  assign b_abs = (is_signed && b_r[WIDTH-1])   ? -b_r   : b_r;

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (b_r),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      a_raw       <= '0;
      b_r         <= '0;
      is_div      <= 1'b0;
      is_signed   <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == ST_IDLE) begin
        // mthi/mtlo land even alongside an accepted start; the result overwrites them later.
        if (hi_we) hi <= operand_a;
        if (lo_we) lo <= operand_a;
        if (start && is_muldiv_func(func)) begin
          state     <= ST_PREP;
          a_raw     <= operand_a;
          b_r       <= operand_b;
          is_div    <= func[1];
          is_signed <= ~func[0];
        end
      end else if (cancel) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_PREP: begin
            acc     <= {{WIDTH{1'b0}}, a_abs};
            b_r     <= b_abs;
            neg_res <= is_signed & (a_raw[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_rem <= is_signed & a_raw[WIDTH-1];
            b_zero  <= (b_r == '0);
            cnt     <= '0;
            state   <= ST_RUN;
          end
          ST_RUN: begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX) state <= ST_FIX;
          end
          ST_FIX: begin
            state <= ST_IDLE;
            done  <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (b_zero) begin
              // Division by zero reports the untouched dividend rather than the iteration result.
              hi          <= a_raw;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: result table plus hand-written multi-cycle sequences.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W = 32;
  localparam int NV = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   func = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic         cancel = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[NV];

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .func        (func),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k0 = cycles already elapsed since the accepting edge; returns with done sampled high.
  task automatic wait_done(input string nm, input int k0);
    int  k;
    bit  busy_ok;
    k = k0;
    busy_ok = 1'b1;
    while (k < 60) begin
      tick();
      k++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    chk($sformatf("%s busy_held", nm), 64'(busy_ok), 64'd1);
    chk($sformatf("%s latency", nm), 64'(k), 64'd34);
    chk($sformatf("%s busy_at_done", nm), 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string nm, input vec_t v);
    func = v.func;
    operand_a = v.a;
    operand_b = v.b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("%s busy_accept", nm), 64'(busy), 64'd1);
    wait_done(nm, 0);
    chk($sformatf("%s hi", nm), 64'(hi), 64'(v.exp_hi));
    chk($sformatf("%s lo", nm), 64'(lo), 64'(v.exp_lo));
    chk($sformatf("%s dbz", nm), 64'(div_by_zero), 64'(v.exp_dbz));
    tick();
    chk($sformatf("%s done_pulse", nm), 64'(done), 64'd0);
    chk($sformatf("%s dbz_pulse", nm), 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    bit saw_done;

    vecs[0]  = '{FUNC_MULTU, 32'd100,        32'd75,         32'h0000_0000, 32'd7500,       1'b0};
    vecs[1]  = '{FUNC_MULT,  32'd99999,      32'hFFFF_FC19,  32'hFFFF_FFFF, 32'hFA0B_A987,  1'b0};
    vecs[2]  = '{FUNC_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001,  1'b0};
    vecs[3]  = '{FUNC_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD,  1'b0};
    vecs[4]  = '{FUNC_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000,  1'b0};
    vecs[5]  = '{FUNC_DIVU,  32'd999,        32'd0,          32'd999,       32'hFFFF_FFFF,  1'b1};
    vecs[6]  = '{FUNC_DIVU,  32'd100,        32'd7,          32'd2,         32'd14,         1'b0};
    vecs[7]  = '{FUNC_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD,  1'b0};
    vecs[8]  = '{FUNC_MULT,  32'hFFFF_FFFD,  32'hFFFF_FFFC,  32'd0,         32'd12,         1'b0};
    vecs[9]  = '{FUNC_DIV,   32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1};
    vecs[10] = '{FUNC_MULTU, 32'h0001_0000,  32'h0001_0000,  32'd1,         32'd0,          1'b0};
    vecs[11] = '{FUNC_DIVU,  32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F, 32'h0FFF_FFFF,  1'b0};

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // mthi / mtlo in IDLE
    operand_a = 32'h1234_5678;
    hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    operand_a = 32'h9ABC_DEF0;
    lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h9ABC_DEF0);

    // Unknown func with start is a no-op
    func = FUNC_ADD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("badfunc busy", 64'(busy), 64'd0);
    tick();
    chk("badfunc done", 64'(done), 64'd0);

    // mthi/mtlo coinciding with an accepted start, then overwritten by the result
    func = FUNC_MULTU;
    operand_a = 32'd6;
    operand_b = 32'd7;
    start = 1'b1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("coinc hi_written", 64'(hi), 64'd6);
    chk("coinc lo_written", 64'(lo), 64'd6);
    wait_done("coinc", 0);
    chk("coinc hi", 64'(hi), 64'd0);
    chk("coinc lo", 64'(lo), 64'd42);

    // start and hi_we while busy are ignored; next start accepted in the done cycle
    tick();
    func = FUNC_DIVU;
    operand_a = 32'd9999;
    operand_b = 32'd9999;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    func = FUNC_MULT;
    operand_a = 32'd7;
    operand_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    operand_a = 32'h0000_DEAD;
    hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    wait_done("busy_ign", 5);
    chk("busy_ign lo", 64'(lo), 64'd1);
    chk("busy_ign hi", 64'(hi), 64'd0);
    func = FUNC_MULT;
    operand_a = 32'd7;
    operand_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    wait_done("b2b", 0);
    chk("b2b lo", 64'(lo), 64'd49);
    chk("b2b hi", 64'(hi), 64'd0);

    // Cancel at cycle 10 of an operation
    func = FUNC_MULTU;
    operand_a = 32'd5;
    operand_b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("cancel no_done", 64'(saw_done), 64'd0);
    chk("cancel hi", 64'(hi), 64'd0);
    chk("cancel lo", 64'(lo), 64'd49);

    // cancel and start in the same IDLE cycle: start wins
    func = FUNC_MULTU;
    operand_a = 32'd3;
    operand_b = 32'd3;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    chk("cancel_start busy", 64'(busy), 64'd1);
    wait_done("cancel_start", 0);
    chk("cancel_start lo", 64'(lo), 64'd9);

    // Asynchronous reset mid-RUN
    tick();
    func = FUNC_MULT;
    operand_a = 32'd7;
    operand_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst dbz", 64'(div_by_zero), 64'd0);
    chk("arst hi", 64'(hi), 64'd0);
    chk("arst lo", 64'(lo), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst post busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
